wvb_reader: RTL
===============

Name: wvb_reader

Overview:
Read-side engine for an mDOM waveform buffer. It pops event headers from the header FIFO, streams the event's samples from the buffer RAM (start_addr through stop_addr, with wrap-around) onto a ready/valid output stream, and signals completion. Completion is wvb_rddone together with hdr_rdreq, which lets the write-side overflow controller free the space. It sits between the waveform buffer/header FIFO pair and the readout arbiter.

Parameters:
P_ADR_WIDTH, 12, buffer RAM address width (depth 2^P_ADR_WIDTH words)
P_DATA_WIDTH, 22, buffer RAM word width

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
en  in  1  allows a new event to start; does not abort an event in progress
hdr_empty  in  1  header FIFO empty (show-ahead FIFO; head valid when low)
hdr_start_addr  in  P_ADR_WIDTH  first sample address of head event (from header fan-out)
hdr_stop_addr  in  P_ADR_WIDTH  last sample address of head event (from header fan-out)
hdr_rdreq  out  1  header FIFO pop, 1-cycle pulse
wvb_rd_addr  out  P_ADR_WIDTH  buffer RAM read address
wvb_rd_data  in  P_DATA_WIDTH  RAM data, valid exactly 1 clk after wvb_rd_addr is presented with wvb_rd_en
wvb_rd_en  out  1  RAM read strobe
wvb_rddone  out  1  event fully read, 1-cycle pulse
dout_data  out  P_DATA_WIDTH  sample word
dout_valid  out  1  dout_data valid
dout_ready  in  1  consumer accepts word when dout_valid && dout_ready
dout_sop  out  1  first word of event (qualified by dout_valid)
dout_eop  out  1  last word of event (qualified by dout_valid)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, any time, including mid-event): state IDLE; all outputs 0; wvb_rd_addr 0; internal output FIFO and counters flushed. No rddone/rdreq is generated for an aborted event.
- States: IDLE, STREAM, DONE.
- IDLE -> STREAM when en && !hdr_empty. Latch start/stop. words_left = (stop - start + 1) mod 2^P_ADR_WIDTH, computed in P_ADR_WIDTH+1 bits; a value of 0 is impossible (the overflow controller forbids a full buffer). The same cycle issues the first read, wvb_rd_addr = start with wvb_rd_en = 1.
- Read address increments by 1 modulo 2^P_ADR_WIDTH, so stop < start means the event wraps and reads 2^P_ADR_WIDTH-1 then 0. Reads stop after the word at stop_addr has been issued; no read is ever issued past stop.
- Buffering: 2-entry output FIFO plus in-flight tracking. A read is issued when (entries + in_flight) < 2, or when it equals 2 and a pop occurs this cycle. With dout_ready held high, throughput is 1 word/clk.
- Latency: dout_valid first rises exactly 2 clks after the IDLE cycle that saw en && !hdr_empty (1 RAM clk + registered output).
- Output rules: dout_data, dout_sop, dout_eop and dout_valid are registered and stay stable while dout_valid && !dout_ready. dout_sop is set only on the first word; dout_eop only on the word read from stop_addr. A single-word event has sop and eop on the same word.
- STREAM -> DONE on the cycle the eop word is accepted.
- DONE (1 clk): hdr_rdreq = 1 and wvb_rddone = 1 in the same cycle, so the header (stop_addr) is still at the FIFO head when the overflow controller samples it. Then DONE -> IDLE.
- Back-to-back events: earliest next start is the IDLE cycle after DONE, giving a 2-clk gap between eop acceptance and the next wvb_rd_en.
- en dropping mid-event has no effect on the current event; it only blocks the next IDLE -> STREAM.
- hdr_empty rising during STREAM is an upstream error and is ignored.

Test Plan:
- start=0x010, stop=0x013, RAM data = address, dout_ready=1 -> 4 words 0x010..0x013 on consecutive clks; sop on the 1st, eop on the 4th; first valid 2 clks after start; rddone+rdreq together 1 clk after eop, both for 1 clk only.
- Wrap: start=0xFFE, stop=0x001 -> words 0xFFE, 0xFFF, 0x000, 0x001; no read of 0x002.
- start=stop=0x123 -> exactly 1 word with sop=eop=1; exactly one rd_en pulse.
- 8-word event, dout_ready toggled 1,0,0,1,... -> no word lost or duplicated; outputs stable while stalled; at most 2 reads outstanding/buffered.
- en=0 with header pending -> busy=0 and no rd_en; en=1 then en=0 after 1 clk -> the full event completes.
- rst_n pulsed low after the 3rd word of a 6-word event -> outputs 0 immediately; no rddone; after release with en=1 the same header restarts from start_addr.

Source files
------------

// File: rtl/wvb_reader.sv
// wvb_reader: read-side engine for the mDOM waveform buffer.
// Pops one event header at a time, streams start..stop (with wrap) from the
// buffer RAM through a 2-entry output FIFO, then pulses rddone with rdreq.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for en with a header at the FIFO head
// STREAM  | issuing RAM reads and draining words onto dout
// DONE    | eop accepted; pop header and pulse rddone for one clk
module wvb_reader #(
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_DATA_WIDTH = 22
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hdr_empty,
    input  logic [P_ADR_WIDTH-1:0]  hdr_start_addr,
    input  logic [P_ADR_WIDTH-1:0]  hdr_stop_addr,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
    output logic                    wvb_rd_en,
    output logic                    wvb_rddone,
    output logic [P_DATA_WIDTH-1:0] dout_data,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_sop,
    output logic                    dout_eop,
    output logic                    busy
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = 1;
    localparam logic [P_ADR_WIDTH:0]   WL_ONE  = 1;
    localparam logic [P_ADR_WIDTH:0]   WL_ZERO = 0;

    state_t                  state_q, state_d;
    logic [P_ADR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [P_ADR_WIDTH:0]    words_left_q, words_left_d;
    logic                    infl_q, infl_d;
    logic                    infl_sop_q, infl_sop_d;
    logic                    infl_eop_q, infl_eop_d;
    logic                    out_valid_q, out_valid_d;
    logic [P_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_sop_q, out_sop_d;
    logic                    out_eop_q, out_eop_d;
    logic                    skid_valid_q, skid_valid_d;
    logic [P_DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                    skid_sop_q, skid_sop_d;
    logic                    skid_eop_q, skid_eop_d;

    logic [P_ADR_WIDTH-1:0]  span;
    logic                    pop;
    logic [1:0]              occ;
    logic                    room;
    logic                    issue;
    logic                    issue_sop;
    logic                    issue_eop;
    logic [P_ADR_WIDTH-1:0]  issue_addr;

    // Next-state, read issue and header handshake.
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        words_left_d = words_left_q;
        issue        = 1'b0;
        issue_sop    = 1'b0;
        issue_eop    = 1'b0;
        issue_addr   = rd_addr_q;
        hdr_rdreq    = 1'b0;
        wvb_rddone   = 1'b0;

        // stop < start wraps naturally in modulo arithmetic
        span = hdr_stop_addr - hdr_start_addr + ADR_ONE;
        pop  = out_valid_q & dout_ready;
        // words already committed: buffered plus the one read in flight
        occ  = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, infl_q};
        room = (occ < 2'd2) || ((occ == 2'd2) && pop);

        case (state_q)
            S_IDLE: begin
                // rst_n keeps the strobe quiet while reset is still held
                if (rst_n && en && !hdr_empty) begin
                    issue        = 1'b1;
                    issue_addr   = hdr_start_addr;
                    issue_sop    = 1'b1;
                    issue_eop    = (span == ADR_ONE);
                    rd_addr_d    = hdr_start_addr + ADR_ONE;
                    words_left_d = {1'b0, span} - WL_ONE;
                    state_d      = S_STREAM;
                end
            end
            S_STREAM: begin
                if ((words_left_q != WL_ZERO) && room) begin
                    issue        = 1'b1;
                    issue_eop    = (words_left_q == WL_ONE);
                    rd_addr_d    = rd_addr_q + ADR_ONE;
                    words_left_d = words_left_q - WL_ONE;
                end
                if (pop && out_eop_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                hdr_rdreq  = 1'b1;
                wvb_rddone = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        infl_d     = issue;
        infl_sop_d = issue_sop;
        infl_eop_d = issue_eop;
    end

    // Output FIFO: slot "out" drives dout, "skid" holds the word behind it.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_sop_d   = skid_sop_q;
        skid_eop_d   = skid_eop_q;

        if (pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_sop_d    = skid_sop_q;
                out_eop_d    = skid_eop_q;
                skid_valid_d = infl_q;
                if (infl_q) begin
                    skid_data_d = wvb_rd_data;
                    skid_sop_d  = infl_sop_q;
                    skid_eop_d  = infl_eop_q;
                end
            end else begin
                out_valid_d = infl_q;
                if (infl_q) begin
                    out_data_d = wvb_rd_data;
                    out_sop_d  = infl_sop_q;
                    out_eop_d  = infl_eop_q;
                end
            end
        end else if (infl_q) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = wvb_rd_data;
                out_sop_d   = infl_sop_q;
                out_eop_d   = infl_eop_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = wvb_rd_data;
                skid_sop_d   = infl_sop_q;
                skid_eop_d   = infl_eop_q;
            end
        end
    end

    // State, read pointer, in-flight tag and FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rd_addr_q    <= '0;
            words_left_q <= '0;
            infl_q       <= 1'b0;
            infl_sop_q   <= 1'b0;
            infl_eop_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sop_q   <= 1'b0;
            skid_eop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            words_left_q <= words_left_d;
            infl_q       <= infl_d;
            infl_sop_q   <= infl_sop_d;
            infl_eop_q   <= infl_eop_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sop_q   <= skid_sop_d;
            skid_eop_q   <= skid_eop_d;
        end
    end

    assign wvb_rd_en   = issue;
    assign wvb_rd_addr = issue_addr;
    assign dout_valid  = out_valid_q;
    assign dout_data   = out_data_q;
    assign dout_sop    = out_sop_q;
    assign dout_eop    = out_eop_q;
    assign busy        = (state_q != S_IDLE);

endmodule
